// File: rtl/reg_file_operand_stage_pkg.sv
// Shared register-file parameters and MB operand-select encodings.
// Used by the operand stage, the ALU and the control unit.
package reg_file_operand_stage_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 2 ** ADDR_W;

  localparam logic MB_REG   = 1'b0;
  localparam logic MB_CONST = 1'b1;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } operands_t;

endpackage

// File: rtl/reg_file_core.sv
// Register storage with one synchronous write port and
// two asynchronous read ports.
module reg_file_core
  import reg_file_operand_stage_pkg::*;
#(
  parameter int DATA_W = reg_file_operand_stage_pkg::DATA_W,
  parameter int ADDR_W = reg_file_operand_stage_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] DA,
  input  logic [DATA_W-1:0] D,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  output logic [DATA_W-1:0] rd_a,
  output logic [DATA_W-1:0] rd_b
);

  localparam int N = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [N];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        mem[i] <= '0;
      end
    end else if (write_en) begin
      mem[DA] <= D;
    end
  end

  assign rd_a = mem[AA];
  assign rd_b = mem[BA];

endmodule

// File: rtl/reg_file_operand_stage.sv
// Register file plus registered A/B operand stage feeding the ALU.
// Define REG_FILE_BYPASS_EN for write-to-read forwarding.
module reg_file_operand_stage
  import reg_file_operand_stage_pkg::*;
#(
  parameter int DATA_W = reg_file_operand_stage_pkg::DATA_W,
  parameter int ADDR_W = reg_file_operand_stage_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              write_en,
  input  logic [ADDR_W-1:0] DA,
  input  logic [DATA_W-1:0] D,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] AA,
  input  logic [ADDR_W-1:0] BA,
  input  logic              MB,
  input  logic [DATA_W-1:0] const_in,
  output logic [DATA_W-1:0] A_bus,
  output logic [DATA_W-1:0] B_bus,
  output logic              operand_valid
);

  logic [DATA_W-1:0] rd_a;
  logic [DATA_W-1:0] rd_b;
  logic [DATA_W-1:0] a_nxt;
  logic [DATA_W-1:0] b_nxt;

  reg_file_core #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .write_en (write_en),
    .DA       (DA),
    .D        (D),
    .AA       (AA),
    .BA       (BA),
    .rd_a     (rd_a),
    .rd_b     (rd_b)
  );

  always_comb begin
    a_nxt = rd_a;
    b_nxt = (MB == MB_CONST) ? const_in : rd_b;
`ifdef REG_FILE_BYPASS_EN
    // forward the in-flight write so a same-edge read sees new data
    if (write_en && (DA == AA)) begin
      a_nxt = D;
    end
    if (write_en && (DA == BA) && (MB == MB_REG)) begin
      b_nxt = D;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      A_bus         <= '0;
      B_bus         <= '0;
      operand_valid <= 1'b0;
    end else begin
      operand_valid <= rd_en;
      if (rd_en) begin
        A_bus <= a_nxt;
        B_bus <= b_nxt;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_operand_stage.sv
// Self-checking bench for reg_file_operand_stage: directed
// vectors plus a per-cycle compare against a behavioural model.
module tb_reg_file_operand_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        write_en;
  logic [2:0]  DA;
  logic [15:0] D;
  logic        rd_en;
  logic [2:0]  AA;
  logic [2:0]  BA;
  logic        MB;
  logic [15:0] const_in;
  logic [15:0] A_bus;
  logic [15:0] B_bus;
  logic        operand_valid;

  int tests = 0;
  int fails = 0;
  bit chk   = 0;

  logic [15:0] m_regs [8];
  logic [15:0] m_a;
  logic [15:0] m_b;
  logic        m_v;

  always #5 clk = ~clk;

  reg_file_operand_stage dut (
    .clk           (clk),
    .reset         (reset),
    .write_en      (write_en),
    .DA            (DA),
    .D             (D),
    .rd_en         (rd_en),
    .AA            (AA),
    .BA            (BA),
    .MB            (MB),
    .const_in      (const_in),
    .A_bus         (A_bus),
    .B_bus         (B_bus),
    .operand_valid (operand_valid)
  );

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
               $time);
    end
  endtask

  // Model: reads see the register contents before this edge's write.
  always @(posedge clk) begin
    logic [15:0] na;
    logic [15:0] nb;
    if (reset) begin
      for (int i = 0; i < 8; i++) m_regs[i] = 16'h0;
      m_a = 16'h0;
      m_b = 16'h0;
      m_v = 1'b0;
    end else begin
      if (rd_en) begin
        na = m_regs[AA];
        nb = MB ? const_in : m_regs[BA];
`ifdef REG_FILE_BYPASS_EN
        if (write_en && DA == AA) na = D;
        if (write_en && DA == BA && !MB) nb = D;
`endif
        m_a = na;
        m_b = nb;
      end
      m_v = rd_en;
      if (write_en) m_regs[DA] = D;
    end
  end

  always @(negedge clk) begin
    if (chk) begin
      check("model_A", A_bus, m_a);
      check("model_B", B_bus, m_b);
      check("model_valid", {15'h0, operand_valid}, {15'h0, m_v});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d);
    write_en = 1'b1;
    DA       = a;
    D        = d;
    tick();
    write_en = 1'b0;
  endtask

  initial begin
    reset    = 1'b1;
    write_en = 1'b0;
    DA       = '0;
    D        = '0;
    rd_en    = 1'b0;
    AA       = '0;
    BA       = '0;
    MB       = 1'b0;
    const_in = '0;
    tick();
    tick();
    reset = 1'b0;
    chk   = 1;

    // reset discards a concurrent write and read
    wr(3'd2, 16'h5555);
    wr(3'd1, 16'h3333);
    reset    = 1'b1;
    write_en = 1'b1;
    DA       = 3'd2;
    D        = 16'hFFFF;
    rd_en    = 1'b1;
    AA       = 3'd1;
    BA       = 3'd2;
    tick();
    check("rst_A", A_bus, 16'h0000);
    check("rst_B", B_bus, 16'h0000);
    check("rst_valid", {15'h0, operand_valid}, 16'h0);
    reset    = 1'b0;
    write_en = 1'b0;
    AA       = 3'd2;
    BA       = 3'd1;
    tick();
    check("rst_R2", A_bus, 16'h0000);
    check("rst_R1", B_bus, 16'h0000);
    rd_en = 1'b0;

    // basic write then read
    wr(3'd3, 16'h1234);
    wr(3'd5, 16'hABCD);
    rd_en = 1'b1;
    AA    = 3'd3;
    BA    = 3'd5;
    MB    = 1'b0;
    tick();
    check("basic_A", A_bus, 16'h1234);
    check("basic_B", B_bus, 16'hABCD);
    check("basic_valid", {15'h0, operand_valid}, 16'h1);
    rd_en = 1'b0;
    tick();
    check("pulse_end", {15'h0, operand_valid}, 16'h0);

    // constant select
    rd_en    = 1'b1;
    MB       = 1'b1;
    const_in = 16'h0007;
    tick();
    check("const_B", B_bus, 16'h0007);
    check("const_A", A_bus, 16'h1234);
    rd_en = 1'b0;

    // hold
    for (int i = 0; i < 4; i++) begin
      AA = 3'(i);
      BA = 3'(7 - i);
      MB = i[0];
      tick();
      check("hold_A", A_bus, 16'h1234);
      check("hold_B", B_bus, 16'h0007);
      check("hold_valid", {15'h0, operand_valid}, 16'h0);
    end

    // read during write
    MB = 1'b0;
    wr(3'd4, 16'h0001);
    write_en = 1'b1;
    DA       = 3'd4;
    D        = 16'h00FF;
    rd_en    = 1'b1;
    AA       = 3'd4;
    BA       = 3'd4;
    tick();
    write_en = 1'b0;
`ifdef REG_FILE_BYPASS_EN
    check("rdw_A", A_bus, 16'h00FF);
    check("rdw_B", B_bus, 16'h00FF);
`else
    check("rdw_A", A_bus, 16'h0001);
    check("rdw_B", B_bus, 16'h0001);
`endif
    tick();
    check("rdw_next", A_bus, 16'h00FF);
    rd_en = 1'b0;

    // exhaustive sweep, back-to-back reads
    for (int i = 0; i < 8; i++) wr(3'(i), 16'(i * 16'h1111));
    rd_en = 1'b1;
    MB    = 1'b0;
    for (int i = 0; i < 64; i++) begin
      AA = 3'(i / 8);
      BA = 3'(i % 8);
      tick();
      check("sweep_A", A_bus, 16'((i / 8) * 16'h1111));
      check("sweep_B", B_bus, 16'((i % 8) * 16'h1111));
      check("sweep_valid", {15'h0, operand_valid}, 16'h1);
    end
    rd_en = 1'b0;
    tick();
    @(negedge clk);
    chk = 0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
